// File: rtl/match_window_counter.sv
// Counts upstream detect pulses over a programmable window of N cycles. The result
// saturates at the counter's maximum and is held until the consumer takes it.
module match_window_counter #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             det_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REPORT} state_t;

  state_t           r_state, w_next;
  logic [WIN_W-1:0] r_len, r_cyc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             w_accept, w_last, w_cnt_max;

  assign w_accept  = (r_state == S_IDLE) && start_i && (win_len_i != '0);
  assign w_last    = (r_cyc == r_len - WIN_W'(1));
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_COUNT;
      S_COUNT:  if (w_last) w_next = S_REPORT;
      S_REPORT: if (rdy_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // r_cyc indexes the window cycle being sampled (0..N-1); counting stops on the Nth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len <= '0;
      r_cyc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_len <= win_len_i;
      r_cyc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (r_state == S_COUNT) begin
      r_cyc <= r_cyc + WIN_W'(1);
      if (det_i) begin
        if (w_cnt_max) r_sat <= 1'b1;
        else           r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt_o  = r_cnt;
  assign sat_o  = r_sat;
  assign vld_o  = (r_state == S_REPORT);
  assign busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_match_window_counter.sv
// Randomized bench for match_window_counter: a window-level model sums detect
// pulses and clamps to the counter maximum, checked against cycle-level outputs.
module tb_match_window_counter;
  localparam int WW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, det, rdy;
  logic [WW-1:0] len;
  logic [CW-1:0] cnt;
  logic          sat, vld, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int last_cnt = 0;
  int last_sat = 0;

  match_window_counter #(.WIN_W(WW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .win_len_i(len), .det_i(det),
    .cnt_o(cnt), .sat_o(sat), .vld_o(vld), .rdy_i(rdy), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int hits);
    return (hits > CMAX) ? CMAX : hits;
  endfunction

  function automatic int exp_sat(input int hits);
    return (hits > CMAX) ? 1 : 0;
  endfunction

  // One full window: accept, N sampled cycles, hold with rdy low, handshake.
  // noise drives start/win_len/rdy/det where they must be ignored.
  task automatic run_win(input int wl, input logic [63:0] pat, input bit rnd,
                         input int dens, input int hold, input bit noise);
    int hits = 0;
    @(negedge clk);
    start = 1'b1; len = WW'(wl);
    det = noise ? 1'($urandom_range(1)) : 1'b0;
    rdy = noise ? 1'($urandom_range(1)) : 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= wl; i++) begin
      chk("busy_win", busy, 1);
      chk("vld_win", vld, 0);
      chk("cnt_run", cnt, exp_cnt(hits));
      chk("sat_run", sat, exp_sat(hits));
      det = rnd ? 1'($urandom_range(99) < dens) : pat[i-1];
      if (det) hits++;
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) len = WW'($urandom);
      rdy = noise ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
    end
    rdy = 1'b0;
    chk("vld_rep", vld, 1);
    chk("busy_rep", busy, 1);
    chk("cnt_rep", cnt, exp_cnt(hits));
    chk("sat_rep", sat, exp_sat(hits));
    for (int h = 0; h < hold; h++) begin
      det   = noise ? 1'($urandom_range(1)) : 1'b1;
      start = noise ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      chk("vld_hold", vld, 1);
      chk("cnt_hold", cnt, exp_cnt(hits));
      chk("sat_hold", sat, exp_sat(hits));
    end
    rdy = 1'b1; start = 1'b1; det = 1'b1; len = 8'd5;
    @(negedge clk);
    rdy = 1'b0; start = 1'b0; det = 1'b0;
    chk("vld_done", vld, 0);
    chk("busy_done", busy, 0);
    chk("cnt_done", cnt, exp_cnt(hits));
    chk("sat_done", sat, exp_sat(hits));
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("cnt_idle", cnt, exp_cnt(hits));
    last_cnt = exp_cnt(hits);
    last_sat = exp_sat(hits);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; det = 1'b1; rdy = 1'b1; len = 8'd7;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0; start = 1'b0; det = 1'b0; rdy = 1'b0;

    // Detects on window cycles 2,4,7 of a 10-cycle window, held 5 cycles.
    run_win(10, 64'h4A, 1'b0, 0, 5, 1'b0);
    // Saturation: 20 consecutive detects into a 4-bit counter.
    run_win(20, '1, 1'b0, 0, 1, 1'b0);
    // Single-cycle window.
    run_win(1, 64'h1, 1'b0, 0, 0, 1'b0);

    // Zero-length start is ignored and leaves outputs alone.
    @(negedge clk);
    start = 1'b1; len = 8'd0; det = 1'b1; rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("zl_busy", busy, 0);
      chk("zl_vld", vld, 0);
      chk("zl_cnt", cnt, last_cnt);
      chk("zl_sat", sat, last_sat);
    end
    start = 1'b0; det = 1'b0; rdy = 1'b0;

    // Starts and win_len changes mid-window must not disturb it.
    run_win(12, 64'h0A5F, 1'b0, 0, 2, 1'b1);

    // Reset on the 3rd window cycle aborts, with priority over other inputs.
    @(negedge clk);
    start = 1'b1; len = 8'd10;
    @(negedge clk);
    start = 1'b0; det = 1'b1;
    repeat (2) @(negedge clk);
    chk("ab_cnt_pre", cnt, 2);
    rst = 1'b1; start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; rdy = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_cnt", cnt, 0);
    chk("ab_sat", sat, 0);
    chk("ab_vld", vld, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ab_novld", vld, 0);
    end
    det = 1'b0;

    for (int t = 0; t < 25; t++)
      run_win($urandom_range(40, 1), '0, 1'b1, $urandom_range(100), $urandom_range(3), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
